// File: rtl/jpeg_soc_pkg.sv
// Shared types and address map for the JPEG result-stream reader.
// Holds the RAM-side defaults and the reader FSM encoding.
package jpeg_soc_pkg;

  localparam int unsigned WIDTH_DEF      = 32;
  localparam int unsigned DEPTH_DEF      = 1200;
  localparam int unsigned ADDROFFSET_DEF = 206800;
  localparam int unsigned CTRL_ADDR_DEF  = 411698;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND,
    ACK
  } rd_state_t;

endpackage

// File: rtl/jpeg_stream_reader_if.sv
// RAM port-2 bus plus the outgoing byte stream, bundled.
// Optional out_last exists only with STREAM_LAST_EN defined.
interface jpeg_stream_reader_if #(
  parameter int unsigned WIDTH = 32
);

  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_enw;
  logic [WIDTH-1:0] mem_rdata;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready;
`ifdef STREAM_LAST_EN
  logic             out_last;

  modport master (
    output mem_addr, mem_wdata, mem_enw,
    input  mem_rdata,
    output out_data, out_valid, out_last,
    input  out_ready
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_enw,
    output mem_rdata,
    input  out_data, out_valid, out_last,
    output out_ready
  );
`else
  modport master (
    output mem_addr, mem_wdata, mem_enw,
    input  mem_rdata,
    output out_data, out_valid,
    input  out_ready
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_enw,
    output mem_rdata,
    input  out_data, out_valid,
    output out_ready
  );
`endif

endinterface

// File: rtl/word_serializer.sv
// Splits one 32-bit word into 4 bytes, MSB first, on valid/ready.
// word_done marks the handshake of the 4th byte.
module word_serializer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] din,
  input  logic        ready,
  output logic        valid,
  output logic [7:0]  data,
  output logic [1:0]  bcnt,
  output logic        word_done
);

  logic [31:0] shift_q, shift_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic        valid_q, valid_d;
  logic        fire;

  assign fire      = valid_q & ready;
  assign word_done = fire & (bcnt_q == 2'd3);
  assign valid     = valid_q;
  assign data      = shift_q[31:24];
  assign bcnt      = bcnt_q;

  // Load a fresh word, or advance one byte per handshake.
  always_comb begin
    shift_d = shift_q;
    bcnt_d  = bcnt_q;
    valid_d = valid_q;
    if (load) begin
      shift_d = din;
      bcnt_d  = 2'd0;
      valid_d = 1'b1;
    end else if (fire) begin
      shift_d = {shift_q[23:0], 8'h00};
      bcnt_d  = bcnt_q + 2'd1;
      if (bcnt_q == 2'd3) valid_d = 1'b0;
    end
  end

  // Byte shifter state.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      bcnt_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      bcnt_q  <= bcnt_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/jpeg_stream_reader.sv
// Polls the control word, streams N result words out as bytes,
// then acks with a zero write. Optional out_last: STREAM_LAST_EN.
module jpeg_stream_reader
  import jpeg_soc_pkg::*;
#(
  parameter int unsigned WIDTH      = WIDTH_DEF,
  parameter int unsigned DEPTH      = DEPTH_DEF,
  parameter int unsigned ADDROFFSET = ADDROFFSET_DEF,
  parameter int unsigned CTRL_ADDR  = CTRL_ADDR_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  jpeg_stream_reader_if.master bus,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  rd_state_t state_q, state_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [CW-1:0] count_q, count_d;
  logic          busy_q, busy_d;
  logic          fd_q, fd_d;
  logic          load;
  logic          last_word;
  logic          ser_valid;
  logic          word_done;
  logic [1:0]    bcnt;
  logic [7:0]    ser_data;
  logic          rd_zero;

  assign rd_zero   = (bus.mem_rdata == '0);
  assign last_word = (idx_q == count_q - CW'(1));

  word_serializer u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .din       (bus.mem_rdata[31:0]),
    .ready     (bus.out_ready),
    .valid     (ser_valid),
    .data      (ser_data),
    .bcnt      (bcnt),
    .word_done (word_done)
  );

  assign bus.out_valid = ser_valid;
  assign bus.out_data  = ser_data;
  assign busy          = busy_q;
  assign frame_done    = fd_q;

  // Next-state logic for the poll / fetch / send / ack sequence.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    count_d = count_q;
    fd_d    = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rd_zero) begin
          count_d = (bus.mem_rdata > WIDTH'(DEPTH)) ?
                    CW'(DEPTH) : bus.mem_rdata[CW-1:0];
          idx_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        load    = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        if (word_done) begin
          if (last_word) begin
            state_d = ACK;
          end else begin
            idx_d   = idx_q + CW'(1);
            state_d = FETCH;
          end
        end
      end
      ACK: begin
        if (rd_zero) begin
          fd_d    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // FSM state and its registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      fd_q    <= fd_d;
    end
  end

  // RAM port-2 controls decoded from the current state.
  always_comb begin
    bus.mem_addr  = WIDTH'(CTRL_ADDR);
    bus.mem_wdata = '0;
    bus.mem_enw   = 1'b0;
    unique case (state_q)
      FETCH, SEND: bus.mem_addr = WIDTH'(ADDROFFSET) + WIDTH'(idx_q);
      ACK:         bus.mem_enw  = 1'b1;
      default:     bus.mem_enw  = 1'b0;
    endcase
  end

`ifdef STREAM_LAST_EN
  logic last_q, last_d;

  // Flag the final byte of the final word as it becomes current.
  always_comb begin
    last_d = last_q;
    if (ser_valid && bus.out_ready)
      last_d = (bcnt == 2'd2) && last_word;
  end

  // Registered end-of-frame marker.
  always_ff @(posedge clk) begin
    if (rst) last_q <= 1'b0;
    else     last_q <= last_d;
  end

  assign bus.out_last = last_q;
`else
  logic unused_bcnt;
  assign unused_bcnt = ^bcnt;
`endif

endmodule

// File: tb/tb_jpeg_stream_reader.sv
// Self-checking bench: RAM model with delayed port-2 commit,
// random data/ready, reference byte stream built from the buffer.
module tb_jpeg_stream_reader;
  import jpeg_soc_pkg::*;

  localparam int OFF  = ADDROFFSET_DEF;
  localparam int CTRL = CTRL_ADDR_DEF;
  localparam int DEP  = DEPTH_DEF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, frame_done;

  jpeg_stream_reader_if #(.WIDTH(32)) bus ();

  jpeg_stream_reader dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] buf_mem [DEP];
  logic [31:0] ctrl = 32'h0;
  logic [31:0] cpu_val = 32'h0;
  bit          cpu_wr = 1'b0;
  int          delay = 1;
  bit          wr_pend = 1'b0;
  int          wr_cnt = 0;
  logic [31:0] wr_data = 32'h0;
  int          cyc = 0;
  int          start_cyc = 0;
  int          rmode = 0;

  // Asynchronous read port of the shared RAM.
  always_comb begin
    int a;
    a = int'(bus.mem_addr);
    bus.mem_rdata = 32'h0;
    if (a == CTRL) bus.mem_rdata = ctrl;
    else if (a >= OFF && a < OFF + DEP) bus.mem_rdata = buf_mem[a - OFF];
  end

  // CPU writes commit at once; port-2 writes commit `delay` edges late.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cpu_wr) begin
      ctrl      <= cpu_val;
      start_cyc <= cyc + 1;
      wr_pend   <= 1'b0;
    end else if (wr_pend) begin
      if (wr_cnt <= 1) begin
        ctrl    <= wr_data;
        wr_pend <= 1'b0;
      end else begin
        wr_cnt <= wr_cnt - 1;
      end
    end else if (bus.mem_enw && !rst) begin
      wr_pend <= 1'b1;
      wr_cnt  <= delay;
      wr_data <= bus.mem_wdata;
    end
  end

  // Sink ready: always on, random, or the 1-0-0-1 pattern.
  int rpat_i = 0;
  always @(posedge clk) begin
    #1;
    case (rmode)
      0: bus.out_ready = 1'b1;
      1: bus.out_ready = 1'($urandom_range(0, 1));
      default: begin
        bus.out_ready = (rpat_i % 4 == 0) || (rpat_i % 4 == 3);
        rpat_i++;
      end
    endcase
  end

  logic [7:0] got[$];
  int         gcyc[$];
  int         fd_cnt = 0, fd_bad = 0, enw_cnt = 0, stall_err = 0;
  int         last_cnt = 0, last_pos = 0, last_bad = 0;
  int         max_addr = 0;
  bit         p_valid = 0, p_ready = 0, p_enw = 0, p_rd0 = 0;
  logic [7:0] p_data = 8'h0;

  // Observe the stream half a cycle before each handshake edge.
  always @(negedge clk) begin
    int a;
    if (rst) begin
      p_valid = 1'b0;
      p_enw   = 1'b0;
    end else begin
      if (p_valid && !p_ready &&
          !(bus.out_valid && bus.out_data == p_data))
        stall_err++;
      if (bus.out_valid && bus.out_ready) begin
        got.push_back(bus.out_data);
        gcyc.push_back(cyc);
`ifdef STREAM_LAST_EN
        if (bus.out_last) begin
          last_cnt++;
          last_pos = got.size();
        end
`endif
      end
`ifdef STREAM_LAST_EN
      if (bus.out_last && !bus.out_valid) last_bad++;
`endif
      if (frame_done) begin
        fd_cnt++;
        if (!(p_enw && p_rd0)) fd_bad++;
      end
      if (bus.mem_enw) enw_cnt++;
      a = int'(bus.mem_addr);
      if (a >= OFF && a < OFF + 8192 && a > max_addr) max_addr = a;
      p_valid = bus.out_valid;
      p_ready = bus.out_ready;
      p_data  = bus.out_data;
      p_enw   = bus.mem_enw;
      p_rd0   = (bus.mem_rdata == 32'h0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input logic [31:0] v);
    @(negedge clk);
    cpu_val = v;
    cpu_wr  = 1'b1;
    @(negedge clk);
    cpu_wr  = 1'b0;
  endtask

  task automatic wait_fd(input string tag, input int fd0, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (fd_cnt != fd0) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_done"}, 32'(ok), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic cmp_stream(input string tag, input int n, input int base);
    logic [7:0] exp_q[$];
    int nn, bad;
    nn  = (n > DEP) ? DEP : n;
    bad = 0;
    for (int w = 0; w < nn; w++)
      for (int b = 0; b < 4; b++)
        exp_q.push_back(8'(buf_mem[w] >> (24 - 8 * b)));
    chk({tag, "_len"}, 32'(got.size() - base), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && base + k < got.size(); k++)
      if (got[base + k] !== exp_q[k]) bad++;
    chk({tag, "_bytes"}, 32'(bad), 32'd0);
  endtask

  initial begin
    int gb, fd0, e0, n, bad, lc0;
    logic [5:0] outs;
    for (int i = 0; i < DEP; i++) buf_mem[i] = 32'h0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_addr", bus.mem_addr, 32'(CTRL));
    outs = {bus.mem_enw, bus.out_valid, busy, frame_done,
            |bus.out_data, |bus.mem_wdata};
    @(posedge clk); #1;
    outs = {bus.mem_enw, bus.out_valid, busy, frame_done,
            |bus.out_data, |bus.mem_wdata};
    chk("rst_outs", 32'(outs), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Control word 0 for 100 cycles: nothing moves.
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy || bus.out_valid || bus.mem_enw) bad++;
    end
    chk("idle_quiet", 32'(bad), 32'd0);

    // Two words, ready always high.
    buf_mem[0] = 32'h11223344;
    buf_mem[1] = 32'hAABBCCDD;
    rmode = 0; delay = 1;
    gb = got.size(); fd0 = fd_cnt; lc0 = last_cnt;
    cpu_write(32'd2);
    wait_fd("two", fd0, 200);
    cmp_stream("two", 2, gb);
    if (got.size() >= gb + 8) begin
      chk("two_latency", 32'(gcyc[gb] - start_cyc), 32'd2);
      chk("two_inword", 32'(gcyc[gb + 3] - gcyc[gb]), 32'd3);
      chk("two_gap", 32'(gcyc[gb + 4] - gcyc[gb + 3]), 32'd2);
    end else begin
      chk("two_count", 32'(got.size() - gb), 32'd8);
    end
    chk("two_fd_once", 32'(fd_cnt - fd0), 32'd1);
    chk("two_ctrl", ctrl, 32'd0);
    chk("two_busy", 32'(busy), 32'd0);
`ifdef STREAM_LAST_EN
    chk("two_last", 32'(last_pos), 32'(gb + 8));
    chk("two_last_cnt", 32'(last_cnt - lc0), 32'd1);
`endif

    // Stalling sink on a single word.
    buf_mem[0] = 32'hDEADBEEF;
    rmode = 2;
    gb = got.size(); fd0 = fd_cnt;
    cpu_write(32'd1);
    wait_fd("stall", fd0, 200);
    cmp_stream("stall", 1, gb);
    chk("stall_hold", 32'(stall_err), 32'd0);

    // Late ACK commit.
    rmode = 0; delay = 3;
    buf_mem[0] = $urandom; buf_mem[1] = $urandom;
    gb = got.size(); fd0 = fd_cnt; e0 = enw_cnt;
    cpu_write(32'd2);
    wait_fd("slow_ack", fd0, 200);
    cmp_stream("slow_ack", 2, gb);
    chk("slow_enw_hold", 32'((enw_cnt - e0) >= 3), 32'd1);
    chk("slow_fd_once", 32'(fd_cnt - fd0), 32'd1);
    chk("slow_fd_when", 32'(fd_bad), 32'd0);

    // Random frames, random sink, random commit delay.
    for (int t = 0; t < 4; t++) begin
      n = $urandom_range(1, 6);
      for (int w = 0; w < n; w++) buf_mem[w] = $urandom;
      rmode = 1; delay = $urandom_range(1, 3);
      gb = got.size(); fd0 = fd_cnt;
      cpu_write(32'(n));
      wait_fd("rand", fd0, 400);
      cmp_stream("rand", n, gb);
    end
    rmode = 0; delay = 1;
    repeat (4) @(negedge clk);

    // Oversized count clamps to DEPTH.
    for (int w = 0; w < DEP; w++) buf_mem[w] = $urandom;
    gb = got.size(); fd0 = fd_cnt; lc0 = last_cnt;
    cpu_write(32'd5000);
    wait_fd("full", fd0, 8000);
    cmp_stream("full", 5000, gb);
    chk("full_max_addr", 32'(max_addr), 32'(OFF + DEP - 1));
`ifdef STREAM_LAST_EN
    chk("full_last_pos", 32'(last_pos), 32'(gb + 4 * DEP));
    chk("full_last_cnt", 32'(last_cnt - lc0), 32'd1);
    chk("last_no_valid", 32'(last_bad), 32'd0);
`endif

    // Reset mid-frame, then restart from word 0.
    for (int w = 0; w < 4; w++) buf_mem[w] = $urandom;
    gb = got.size();
    cpu_write(32'd4);
    for (int i = 0; i < 200 && got.size() < gb + 7; i++) @(negedge clk);
    chk("mid_reached", 32'(got.size() >= gb + 7), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    outs = {bus.mem_enw, bus.out_valid, busy, frame_done,
            |bus.out_data, |bus.mem_wdata};
    chk("mid_rst_outs", 32'(outs), 32'd0);
    chk("mid_ctrl_kept", ctrl, 32'd4);
    @(negedge clk);
    rst = 1'b0;
    gb = got.size(); fd0 = fd_cnt;
    wait_fd("restart", fd0, 300);
    cmp_stream("restart", 4, gb);
    chk("final_stall", 32'(stall_err), 32'd0);
    chk("final_fd_when", 32'(fd_bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
